dcache_snoop_responder: RTL and testbench
=========================================

// Module: dcache_snoop_responder
// PURPOSE
//  Cache-side end of the bus coherence protocol: one instance per L1 dcache.
//  Answers snoops from the coherence controller (ccwait/ccinv/ccsnoopaddr) by tag lookup, MSI state update and,
//  when the line is Modified, forwarding two block words via daddr/dstore paced by dwait.
//  Takes ownership of cache bus outputs (snp_active) while a snoop is in flight; cache main FSM stalls.
// PARAMETERS
//  SETS   8   sets per way (IDX_W = clog2(SETS)); block = 2 words, fixed by controller
//  WAYS   2   associativity (WAY_W = clog2(WAYS), min 1)
// PORTS
//  CLK          in   1          clock, rising edge
//  nRST         in   1          reset, asynchronous, active-low
//  ccwait       in   1          snoop in progress for this cache (controller SNP/LD phases)
//  ccinv        in   1          snooping requester writes: invalidate on hit
//  ccsnoopaddr  in   32         snooped byte address (stable while ccwait/ccinv high)
//  dwait        in   1          low for one cycle = controller consumed current forwarded word
//  snp_idx      out  IDX_W      set index to tag/data arrays = ccsnoopaddr[IDX_W+2:3]
//  way_tag      in   WAYS*TAG_W tags of indexed set, TAG_W = 29-IDX_W
//  way_valid    in   WAYS       valid bits of indexed set
//  way_dirty    in   WAYS       dirty bits (valid&dirty = M, valid&~dirty = S, ~valid = I)
//  way_data     in   WAYS*64    {word1,word0} per way of indexed set
//  snp_active   out  1          responder owns cctrans/daddr/dstore; cache FSM must not issue requests
//  snp_cctrans  out  1          "I hold it Modified, I supply data" (ORed into cctrans by cache)
//  snp_daddr    out  32         forwarded word address {tag,idx,blk,2'b00}
//  snp_dstore   out  32         forwarded word data
//  upd_en       out  1          one-cycle write strobe to valid/dirty arrays
//  upd_way      out  WAY_W      way to update;  upd_valid/upd_dirty out 1 each: new state bits
//  link_addr    in   32         LL link register address;  link_valid in 1: link register armed
//  link_clear   out  1          one-cycle pulse: snoop invalidated the linked block
// BEHAVIOUR
//  Reset: state IDLE; every output 0; hit/way/mod registers cleared.
//  Lookup (comb, any state): hit = some way valid & tag==ccsnoopaddr[31:IDX_W+3]; one-hot, lowest way wins if corrupted.
//  FSM:
//   IDLE:  ccwait -> LOOK.  ccinv & ~ccwait (bare INV): if hit -> upd_en, upd_valid=0, upd_dirty=0 same cycle; stay IDLE.
//   LOOK:  snp_active=1; register hit, way, mod=hit&dirty. -> RESP.
//   RESP:  snp_active=1; snp_cctrans=mod (must be valid by 2nd cycle after ccwait rose; controller samples 3rd).
//          mod -> SEND0.  ~mod: if hit&ccinv -> upd invalidate; -> DRAIN.
//   SEND0: snp_cctrans=1; snp_daddr=blk 0 addr, snp_dstore=word0 held stable; dwait=0 -> SEND1.
//   SEND1: word1/blk 1 addr held stable; ignore dwait in first SEND1 cycle (controller gap cycle);
//          dwait=0 -> upd_en: ccinv ? M->I (0,0) : M->S (1,0); -> DRAIN.
//   DRAIN: snp_active=1, cctrans=0; wait ccwait=0 -> IDLE (no back-to-back snoop without IDLE cycle).
//  ccwait drops in LOOK/RESP -> IDLE, no update (controller aborted). Reset mid-transfer: IDLE, line state untouched.
//  link_clear: pulses with every invalidating upd_en when link_valid & link_addr[31:3]==ccsnoopaddr[31:3].
//  Same-cycle ccinv & ccwait in IDLE: treat as snoop (LOOK), not bare INV.
//  Forwarded words: daddr/dstore change only on SEND0->SEND1 edge; latency ccwait↑ -> cctrans = 2 cycles.
//  S hit with ~ccinv: no change, no cctrans (memory supplies). Miss: no update ever.
// STRUCTURE
//  Add to cpu_types_pkg: snoop_state_t {IDLE,LOOK,RESP,SEND0,SEND1,DRAIN}; dcache address struct
//  {tag, idx, blkoff, bytoff}.
//  Sub-module snoop_tag_match: comb WAYS-wide compare -> hit, way (reused by dcache hit logic).
//  FSM + output regs in this file; all outputs driven from one always_comb default block.
// TESTING
//  M hit, ccinv=0, addr 0x0000_1048: cctrans at cycle 2, words sent at 0x1048/0x104C on two dwait lows,
//   way -> S (valid=1, dirty=0).
//  M hit, ccinv=1: same data sequence, final upd_valid=0; link at 0x1048 armed -> link_clear pulse.
//  S hit, ccinv=1: cctrans never asserted, invalidate in RESP, no daddr activity.
//  Miss or S hit, ccinv=0: no upd_en, no cctrans, returns IDLE when ccwait falls.
//  Bare INV (ccinv 1 cycle, ccwait=0) on S line -> same-cycle invalidate; on miss -> nothing.
//  nRST low during SEND1 -> all outputs 0 next edge, line remains M; following snoop serves it again.

Source files
------------

// File: rtl/dcache_snoop_responder_pkg.sv
// Shared types for the dcache snoop responder.
//  snoop_state_t : responder FSM state encoding (legacy-style localparam constants)
//  dcachef_t     : dcache byte-address breakdown for the default 8-set geometry
//  blk_word_addr : builds a forwarded word address from a block address and word select
package dcache_snoop_responder_pkg;

  typedef logic [2:0] snoop_state_t;

  localparam snoop_state_t IDLE  = 3'd0;
  localparam snoop_state_t LOOK  = 3'd1;
  localparam snoop_state_t RESP  = 3'd2;
  localparam snoop_state_t SEND0 = 3'd3;
  localparam snoop_state_t SEND1 = 3'd4;
  localparam snoop_state_t DRAIN = 3'd5;

  // Default geometry: 8 sets, 2-word blocks, 4-byte words.
  localparam int DCACHE_IDX_W = 3;
  localparam int DCACHE_TAG_W = 29 - DCACHE_IDX_W;

  typedef struct packed {
    logic [DCACHE_TAG_W-1:0] tag;
    logic [DCACHE_IDX_W-1:0] idx;
    logic                    blkoff;
    logic [1:0]              bytoff;
  } dcachef_t;

  // blk_addr is the byte address with its low three bits dropped.
  function automatic logic [31:0] blk_word_addr(input logic [28:0] blk_addr, input logic blk);
    return {blk_addr, blk, 2'b00};
  endfunction

endpackage

// File: rtl/dcache_snoop_responder_tag_match.sv
// Combinational tag compare across all ways of one set.
//  tag        in   TAG_W        tag to look up
//  way_tag    in   WAYS*TAG_W   stored tags of the indexed set
//  way_valid  in   WAYS         valid bits of the indexed set
//  hit        out  1            some valid way holds the tag
//  way        out  WAY_W        matching way; lowest index wins if several match
module snoop_tag_match #(
  parameter int WAYS  = 2,
  parameter int TAG_W = 26,
  parameter int WAY_W = 1
) (
  input  logic [TAG_W-1:0]      tag,
  input  logic [WAYS*TAG_W-1:0] way_tag,
  input  logic [WAYS-1:0]       way_valid,
  output logic                  hit,
  output logic [WAY_W-1:0]      way
);

  always_comb begin
    hit = 1'b0;
    way = '0;
    // Scan downwards so the lowest matching way is the last one written.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_valid[w] && (way_tag[w*TAG_W +: TAG_W] == tag)) begin
        hit = 1'b1;
        way = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/dcache_snoop_responder.sv
// Cache-side snoop responder, one per L1 dcache.
// Looks up snooped addresses, updates MSI state bits and forwards a Modified block
// (two words) to the coherence controller, paced by dwait.
//  CLK, nRST                  clock, async active-low reset
//  ccwait, ccinv, ccsnoopaddr snoop request from the coherence controller
//  dwait                      low for one cycle when the forwarded word is consumed
//  snp_idx                    set index driven to the tag/data arrays
//  way_tag/valid/dirty/data   contents of the indexed set
//  snp_active                 responder owns cctrans/daddr/dstore this cycle
//  snp_cctrans                line held Modified, this cache supplies the data
//  snp_daddr, snp_dstore      forwarded word address/data
//  upd_en/way/valid/dirty     one-cycle write strobe into the state arrays
//  link_addr, link_valid      LL link register
//  link_clear                 pulse when a snoop invalidates the linked block
module dcache_snoop_responder
  import dcache_snoop_responder_pkg::*;
#(
  parameter  int SETS  = 8,
  parameter  int WAYS  = 2,
  localparam int IDX_W = $clog2(SETS),
  localparam int TAG_W = 29 - IDX_W,
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  ccwait,
  input  logic                  ccinv,
  input  logic [31:0]           ccsnoopaddr,
  input  logic                  dwait,
  output logic [IDX_W-1:0]      snp_idx,
  input  logic [WAYS*TAG_W-1:0] way_tag,
  input  logic [WAYS-1:0]       way_valid,
  input  logic [WAYS-1:0]       way_dirty,
  input  logic [WAYS*64-1:0]    way_data,
  output logic                  snp_active,
  output logic                  snp_cctrans,
  output logic [31:0]           snp_daddr,
  output logic [31:0]           snp_dstore,
  output logic                  upd_en,
  output logic [WAY_W-1:0]      upd_way,
  output logic                  upd_valid,
  output logic                  upd_dirty,
  input  logic [31:0]           link_addr,
  input  logic                  link_valid,
  output logic                  link_clear
);

  snoop_state_t     state_q, state_d;
  logic             hit_q, hit_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             mod_q, mod_d;
  logic [63:0]      data_q, data_d;
  logic             gap_q;

  logic [TAG_W-1:0] snp_tag;
  logic             lk_hit;
  logic [WAY_W-1:0] lk_way;
  logic             lk_dirty;
  logic [63:0]      lk_data;
  logic             link_match;

  // Byte/word offset bits never take part in the lookup.
  logic unused_bits;
  assign unused_bits = ^{link_addr[2:0], ccsnoopaddr[2:0]};

  assign snp_tag    = ccsnoopaddr[31:IDX_W+3];
  assign lk_dirty   = way_dirty[lk_way];
  assign lk_data    = way_data[int'(lk_way)*64 +: 64];
  assign link_match = link_valid && (link_addr[31:3] == ccsnoopaddr[31:3]);

  snoop_tag_match #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_tag_match (
    .tag       (snp_tag),
    .way_tag   (way_tag),
    .way_valid (way_valid),
    .hit       (lk_hit),
    .way       (lk_way)
  );

  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      way_q   <= '0;
      mod_q   <= 1'b0;
      data_q  <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      way_q   <= way_d;
      mod_q   <= mod_d;
      data_q  <= data_d;
      // First SEND1 cycle is the controller's gap cycle; its dwait is not ours.
      gap_q   <= (state_q == SEND0);
    end
  end

  always_comb begin
    state_d     = state_q;
    hit_d       = hit_q;
    way_d       = way_q;
    mod_d       = mod_q;
    data_d      = data_q;
    snp_idx     = ccsnoopaddr[IDX_W+2:3];
    snp_active  = 1'b0;
    snp_cctrans = 1'b0;
    snp_daddr   = '0;
    snp_dstore  = '0;
    upd_en      = 1'b0;
    upd_way     = '0;
    upd_valid   = 1'b0;
    upd_dirty   = 1'b0;
    link_clear  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ccwait) begin
          // A snoop takes priority over a coincident bare invalidate.
          state_d = LOOK;
        end else if (ccinv && lk_hit) begin
          upd_en     = 1'b1;
          upd_way    = lk_way;
          link_clear = link_match;
        end
      end

      LOOK: begin
        snp_active = 1'b1;
        if (!ccwait) begin
          state_d = IDLE;
        end else begin
          hit_d   = lk_hit;
          way_d   = lk_way;
          mod_d   = lk_hit && lk_dirty;
          data_d  = lk_data;
          state_d = RESP;
        end
      end

      RESP: begin
        snp_active  = 1'b1;
        snp_cctrans = mod_q;
        if (!ccwait) begin
          state_d = IDLE;
        end else if (mod_q) begin
          state_d = SEND0;
        end else begin
          if (hit_q && ccinv) begin
            upd_en     = 1'b1;
            upd_way    = way_q;
            link_clear = link_match;
          end
          state_d = DRAIN;
        end
      end

      SEND0: begin
        snp_active  = 1'b1;
        snp_cctrans = 1'b1;
        snp_daddr   = blk_word_addr(ccsnoopaddr[31:3], 1'b0);
        snp_dstore  = data_q[31:0];
        if (!dwait) state_d = SEND1;
      end

      SEND1: begin
        snp_active  = 1'b1;
        snp_cctrans = 1'b1;
        snp_daddr   = blk_word_addr(ccsnoopaddr[31:3], 1'b1);
        snp_dstore  = data_q[63:32];
        if (!gap_q && !dwait) begin
          // Data handed over: M -> I when the requester writes, otherwise M -> S.
          upd_en     = 1'b1;
          upd_way    = way_q;
          upd_valid  = !ccinv;
          link_clear = ccinv && link_match;
          state_d    = DRAIN;
        end
      end

      DRAIN: begin
        snp_active = 1'b1;
        if (!ccwait) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_snoop_responder.sv
module tb_dcache_snoop_responder;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         ccwait, ccinv, dwait;
  logic [31:0]  ccsnoopaddr;
  logic [2:0]   snp_idx;
  logic [51:0]  way_tag;
  logic [1:0]   way_valid, way_dirty;
  logic [127:0] way_data;
  logic         snp_active, snp_cctrans;
  logic [31:0]  snp_daddr, snp_dstore;
  logic         upd_en;
  logic [0:0]   upd_way;
  logic         upd_valid, upd_dirty;
  logic [31:0]  link_addr;
  logic         link_valid;
  logic         link_clear;

  dcache_snoop_responder #(.SETS(8), .WAYS(2)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ccwait      (ccwait),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .dwait       (dwait),
    .snp_idx     (snp_idx),
    .way_tag     (way_tag),
    .way_valid   (way_valid),
    .way_dirty   (way_dirty),
    .way_data    (way_data),
    .snp_active  (snp_active),
    .snp_cctrans (snp_cctrans),
    .snp_daddr   (snp_daddr),
    .snp_dstore  (snp_dstore),
    .upd_en      (upd_en),
    .upd_way     (upd_way),
    .upd_valid   (upd_valid),
    .upd_dirty   (upd_dirty),
    .link_addr   (link_addr),
    .link_valid  (link_valid),
    .link_clear  (link_clear)
  );

  always #5 CLK = ~CLK;

  // Cache arrays; written only by the DUT's update strobe (or by preload).
  logic [25:0] atag [8][2];
  logic        aval [8][2];
  logic        adir [8][2];
  logic [63:0] adat [8][2];

  always_comb begin
    way_tag   = '0;
    way_valid = '0;
    way_dirty = '0;
    way_data  = '0;
    for (int w = 0; w < 2; w++) begin
      way_tag[w*26 +: 26]  = atag[snp_idx][w];
      way_valid[w]         = aval[snp_idx][w];
      way_dirty[w]         = adir[snp_idx][w];
      way_data[w*64 +: 64] = adat[snp_idx][w];
    end
  end

  int n_cmp = 0;
  int n_fail = 0;
  int n_upd, n_lc;
  bit any_ct;

  logic        s_active, s_ct, s_upd_en, s_upd_v, s_upd_d, s_lc;
  logic [0:0]  s_upd_way;
  logic [2:0]  s_idx;
  logic [31:0] s_daddr, s_dstore;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, apply any array write at the edge.
  task automatic cyc();
    @(negedge CLK);
    s_active = snp_active; s_ct = snp_cctrans; s_daddr = snp_daddr; s_dstore = snp_dstore;
    s_upd_en = upd_en; s_upd_way = upd_way; s_upd_v = upd_valid; s_upd_d = upd_dirty;
    s_lc = link_clear; s_idx = snp_idx;
    if (s_upd_en) n_upd++;
    if (s_lc) n_lc++;
    if (s_ct) any_ct = 1'b1;
    @(posedge CLK);
    if (s_upd_en && nRST) begin
      aval[s_idx][s_upd_way] = s_upd_v;
      adir[s_idx][s_upd_way] = s_upd_d;
    end
    #1;
  endtask

  task automatic clear_all();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) begin
        atag[s][w] = '0; aval[s][w] = 1'b0; adir[s][w] = 1'b0; adat[s][w] = '0;
      end
  endtask

  task automatic load(input logic [31:0] a, input int w, input bit v, input bit d);
    atag[a[5:3]][w] = a[31:6];
    aval[a[5:3]][w] = v;
    adir[a[5:3]][w] = d;
    adat[a[5:3]][w] = {~a, a ^ 32'h5A5A_0000};
  endtask

  task automatic lookup(input logic [31:0] a, output bit hit, output int hw);
    hit = 1'b0;
    hw  = 0;
    for (int w = 0; w < 2; w++)
      if (!hit && aval[a[5:3]][w] && atag[a[5:3]][w] == a[31:6]) begin
        hit = 1'b1;
        hw  = w;
      end
  endtask

  function automatic bit link_hits(input logic [31:0] a);
    return link_valid && (link_addr[31:3] == a[31:3]);
  endfunction

  task automatic bare_inv(input logic [31:0] a);
    bit hit;
    int hw;
    bit elc;
    lookup(a, hit, hw);
    elc = hit && link_hits(a);
    n_upd = 0; n_lc = 0; any_ct = 1'b0;
    ccsnoopaddr = a; ccinv = 1'b1; ccwait = 1'b0; dwait = 1'b1;
    cyc();
    chk("bare_upd_en", s_upd_en, hit);
    if (hit) begin
      chk("bare_upd_way", s_upd_way, hw);
      chk("bare_upd_bits", {s_upd_v, s_upd_d}, 2'b00);
    end
    ccinv = 1'b0;
    cyc();
    chk("bare_n_upd", n_upd, hit);
    chk("bare_n_lc", n_lc, elc);
    chk("bare_active", any_ct | s_active, 0);
    if (hit) chk("bare_final_vd", {aval[a[5:3]][hw], adir[a[5:3]][hw]}, 2'b00);
  endtask

  task automatic run_snoop(input logic [31:0] a, input bit inv, input int d0, input int d1,
                           input bit gap_low, input int dr);
    bit hit, emod, ev, ed, eupd, elc;
    int hw;
    logic [63:0] dat;
    lookup(a, hit, hw);
    emod = hit && adir[a[5:3]][hw];
    dat  = adat[a[5:3]][hw];
    ev   = hit ? aval[a[5:3]][hw] : 1'b0;
    ed   = hit ? adir[a[5:3]][hw] : 1'b0;
    if (emod) begin ev = !inv; ed = 1'b0; end
    else if (hit && inv) begin ev = 1'b0; ed = 1'b0; end
    eupd = hit && (emod || inv);
    elc  = hit && inv && link_hits(a);
    n_upd = 0; n_lc = 0; any_ct = 1'b0;

    ccsnoopaddr = a; ccinv = inv; ccwait = 1'b1; dwait = 1'b1;
    cyc();
    chk("req_cycle_upd", s_upd_en, 0);
    cyc();
    chk("look_active", s_active, 1);
    chk("look_ct", s_ct, 0);
    cyc();
    chk("resp_ct", s_ct, emod);
    chk("resp_upd", s_upd_en, hit && !emod && inv);
    if (!emod) chk("resp_daddr", s_daddr, 0);
    if (emod) begin
      for (int i = 0; i < d0; i++) begin
        cyc();
        chk("send0_hold_daddr", s_daddr, {a[31:3], 3'b000});
        chk("send0_hold_data", s_dstore, dat[31:0]);
      end
      dwait = 1'b0;
      cyc();
      chk("send0_daddr", s_daddr, {a[31:3], 3'b000});
      chk("send0_data", s_dstore, dat[31:0]);
      chk("send0_ct", s_ct, 1);
      dwait = gap_low ? 1'b0 : 1'b1;
      cyc();
      chk("send1_gap_upd", s_upd_en, 0);
      chk("send1_daddr", s_daddr, {a[31:3], 3'b100});
      chk("send1_data", s_dstore, dat[63:32]);
      dwait = 1'b1;
      for (int i = 0; i < d1; i++) begin
        cyc();
        chk("send1_hold_upd", s_upd_en, 0);
        chk("send1_hold_data", s_dstore, dat[63:32]);
      end
      dwait = 1'b0;
      cyc();
      chk("send1_upd_en", s_upd_en, 1);
      chk("send1_upd_way", s_upd_way, hw);
      chk("send1_upd_bits", {s_upd_v, s_upd_d}, {!inv, 1'b0});
      dwait = 1'b1;
    end
    for (int i = 0; i < dr; i++) begin
      cyc();
      chk("drain_ct", s_ct, 0);
      chk("drain_active", s_active, 1);
    end
    ccwait = 1'b0; ccinv = 1'b0;
    cyc();
    cyc();
    chk("idle_active", s_active, 0);
    chk("snoop_n_upd", n_upd, eupd);
    chk("snoop_n_lc", n_lc, elc);
    chk("snoop_any_ct", any_ct, emod);
    if (hit) chk("snoop_final_vd", {aval[a[5:3]][hw], adir[a[5:3]][hw]}, {ev, ed});
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] line;
    int          way;
    bit          pv, pd, inv, bare, lv;
    logic [31:0] la;
    bit          ect, ev, ed, elc;
  } vec_t;

  vec_t vt [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [25:0] tp [3];
    logic [31:0] ra;
    logic [2:0]  rs;

    vt[0] = '{32'h0000_1048, 32'h0000_1048, 1, 1, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0};
    vt[1] = '{32'h0000_1048, 32'h0000_1048, 1, 1, 1, 1, 0, 1, 32'h0000_1048, 1, 0, 0, 1};
    vt[2] = '{32'h0000_2010, 32'h0000_2010, 0, 1, 0, 1, 0, 1, 32'h0000_2014, 0, 0, 0, 1};
    vt[3] = '{32'h0000_2010, 32'h0000_2010, 0, 1, 0, 0, 0, 1, 32'h0000_2010, 0, 1, 0, 0};
    vt[4] = '{32'h0000_1048, 32'h0000_5048, 0, 1, 1, 1, 0, 1, 32'h0000_1048, 0, 1, 1, 0};
    vt[5] = '{32'h0000_3018, 32'h0000_3018, 1, 1, 0, 1, 1, 1, 32'h0000_301C, 0, 0, 0, 1};
    vt[6] = '{32'h0000_7018, 32'h0000_3018, 1, 1, 0, 1, 1, 1, 32'h0000_7018, 0, 1, 0, 0};
    vt[7] = '{32'h0000_0FF8, 32'h0000_0FF8, 0, 1, 1, 1, 0, 1, 32'h0000_0FF0, 1, 0, 0, 0};

    clear_all();
    nRST = 1'b0; ccwait = 1'b0; ccinv = 1'b0; dwait = 1'b1; ccsnoopaddr = '0;
    link_addr = '0; link_valid = 1'b0;
    #12;
    chk("rst_active", snp_active, 0);
    chk("rst_ct", snp_cctrans, 0);
    chk("rst_daddr", snp_daddr, 0);
    chk("rst_dstore", snp_dstore, 0);
    chk("rst_upd", {upd_en, upd_way, upd_valid, upd_dirty}, 0);
    chk("rst_link_clear", link_clear, 0);
    chk("rst_idx", snp_idx, 0);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK) #1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      clear_all();
      load(vt[i].line, vt[i].way, vt[i].pv, vt[i].pd);
      link_valid = vt[i].lv;
      link_addr  = vt[i].la;
      if (vt[i].bare) bare_inv(vt[i].addr);
      else run_snoop(vt[i].addr, vt[i].inv, 1, 1, 1, 1);
      chk($sformatf("vec%0d_ct", i), any_ct, vt[i].ect);
      chk($sformatf("vec%0d_vd", i),
          {aval[vt[i].line[5:3]][vt[i].way], adir[vt[i].line[5:3]][vt[i].way]},
          {vt[i].ev, vt[i].ed});
      chk($sformatf("vec%0d_lc", i), n_lc, vt[i].elc);
    end

    // Controller aborts in LOOK: no update, line stays Modified.
    clear_all();
    load(32'h0000_2058, 0, 1, 1);
    link_valid = 1'b0;
    n_upd = 0; n_lc = 0; any_ct = 1'b0;
    ccsnoopaddr = 32'h0000_2058; ccinv = 1'b1; ccwait = 1'b1; dwait = 1'b1;
    cyc();
    ccwait = 1'b0; ccinv = 1'b0;
    cyc();
    chk("abort_look_active", s_active, 1);
    cyc();
    chk("abort_idle_active", s_active, 0);
    chk("abort_n_upd", n_upd, 0);
    chk("abort_ct", any_ct, 0);
    chk("abort_line_m", {aval[3][0], adir[3][0]}, 2'b11);

    // Reset during SEND1: outputs drop, line remains M, next snoop serves it again.
    clear_all();
    load(32'h0000_1048, 1, 1, 1);
    ccsnoopaddr = 32'h0000_1048; ccinv = 1'b0; ccwait = 1'b1; dwait = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    dwait = 1'b0;
    cyc();
    dwait = 1'b1;
    cyc();
    chk("rstmid_pre_daddr", snp_daddr, 32'h0000_104C);
    nRST = 1'b0;
    #1;
    chk("rstmid_active", snp_active, 0);
    chk("rstmid_ct", snp_cctrans, 0);
    chk("rstmid_data", {snp_daddr, snp_dstore}, 0);
    chk("rstmid_upd", upd_en, 0);
    ccwait = 1'b0;
    cyc(); cyc();
    chk("rstmid_line_m", {aval[1][1], adir[1][1]}, 2'b11);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK) #1;
    run_snoop(32'h0000_1048, 1'b0, 0, 0, 1'b0, 0);
    chk("rstmid_served_s", {aval[1][1], adir[1][1]}, 2'b10);

    // Randomized snoops against the MSI reference model
    for (int it = 0; it < 60; it++) begin
      clear_all();
      rs = 3'($urandom_range(0, 7));
      tp[0] = 26'($urandom);
      tp[1] = tp[0] ^ 26'h1;
      tp[2] = tp[0] ^ 26'h2;
      for (int w = 0; w < 2; w++) begin
        atag[rs][w] = tp[$urandom_range(0, 1)];
        aval[rs][w] = 1'($urandom);
        adir[rs][w] = 1'($urandom);
        adat[rs][w] = {$urandom, $urandom};
      end
      ra = {tp[$urandom_range(0, 2)], rs, 1'($urandom), 2'($urandom)};
      link_valid = 1'($urandom);
      link_addr  = ($urandom_range(0, 1) == 1) ? {ra[31:3], 3'($urandom)} : $urandom;
      if ($urandom_range(0, 3) == 0) bare_inv(ra);
      else run_snoop(ra, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                     1'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
